// File: rtl/hdmi_island_scheduler_pkg.sv
// Shared types and lengths for the HDMI data-island scheduler.
// Period and packet-source encodings are visible to the encoder and assembler.
package hdmi_island_scheduler_pkg;

    typedef enum logic [2:0] {
        CTRL,
        VID_PRE,
        VID_GUARD,
        VIDEO,
        ISL_PRE,
        ISL_GUARD,
        ISL_PKT
    } period_t;

    typedef enum logic [1:0] {
        ACR,
        AUD,
        AVI,
        AIF
    } pkt_src_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_LGUARD,
        S_PKT,
        S_TGUARD
    } isl_state_t;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;

    // Request/grant bit i corresponds to pkt_src_t value i; lowest bit wins.
    function automatic logic [3:0] pick(input logic [3:0] req);
        return req & (~req + 4'd1);
    endfunction

endpackage

// File: rtl/hdmi_req_tracker.sv
// Pending latches for ACR/AVI/AIF packets plus the ACR line divider.
// A set event in the same cycle as a grant leaves the latch pending.
module hdmi_req_tracker
    import hdmi_island_scheduler_pkg::*;
#(
    parameter int V_ACTIVE  = 720,
    parameter int ACR_LINES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcnt,
    input  logic [9:0]  vcnt,
    input  logic [3:0]  grant,
    output logic        acr_pend,
    output logic        avi_pend,
    output logic        aif_pend
);

    localparam int LW = (ACR_LINES > 1) ? $clog2(ACR_LINES) : 1;

    logic [LW-1:0] line_cnt;
    logic          line_start;
    logic          acr_set;
    logic          info_set;

    assign line_start = (hcnt == 11'd0);
    assign acr_set    = line_start && (line_cnt == '0);
    assign info_set   = line_start && (vcnt == 10'(V_ACTIVE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt <= '0;
            acr_pend <= 1'b0;
            avi_pend <= 1'b1;
            aif_pend <= 1'b1;
        end else begin
            if (line_start) begin
                line_cnt <= (line_cnt == LW'(ACR_LINES - 1))
                          ? '0 : line_cnt + 1'b1;
            end
            acr_pend <= acr_set  | (acr_pend & ~grant[ACR]);
            avi_pend <= info_set | (avi_pend & ~grant[AVI]);
            aif_pend <= info_set | (aif_pend & ~grant[AIF]);
        end
    end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// Per-line HDMI period sequencer and data-island packet arbiter.
// Optional ISLAND_STATS_EN adds the aud_miss saturating counter.
module hdmi_island_scheduler
    import hdmi_island_scheduler_pkg::*;
#(
    parameter int H_ACTIVE  = 1280,
    parameter int H_TOTAL   = 1512,
    parameter int V_ACTIVE  = 720,
    parameter int V_TOTAL   = 836,
    parameter int ISL_GAP   = 16,
    parameter int ISL_LIMIT = 1488,
    parameter int MAX_PKTS  = 18,
    parameter int ACR_LINES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcnt,
    input  logic [9:0]  vcnt,
    input  logic        aud_req,
    output period_t     period,
    output pkt_src_t    pkt_src,
    output logic [4:0]  pkt_word,
    output logic [3:0]  grant,
    output logic        isl_first
`ifdef ISLAND_STATS_EN
    ,
    output logic [15:0] aud_miss
`endif
);

    localparam int ISL_START = H_ACTIVE + ISL_GAP;
    localparam int ROOM_MAX  = ISL_LIMIT - 1 - PACKET_LEN - GUARD_LEN;

    isl_state_t state, state_nx, cur_state;
    logic [4:0] cnt, cnt_nx, cur_cnt;
    logic [4:0] npk, npk_nx;
    logic [3:0] req, win;
    logic       pending, more_ok, room_ok, next_act;
    logic       acr_pend, avi_pend, aif_pend;
    period_t    period_d;
    pkt_src_t   src_d;
    logic [4:0] word_d;
    logic       first_d;

    hdmi_req_tracker #(
        .V_ACTIVE (V_ACTIVE),
        .ACR_LINES(ACR_LINES)
    ) u_req (
        .clk     (clk),
        .rst_n   (rst_n),
        .hcnt    (hcnt),
        .vcnt    (vcnt),
        .grant   (win),
        .acr_pend(acr_pend),
        .avi_pend(avi_pend),
        .aif_pend(aif_pend)
    );

    assign req      = {aif_pend, avi_pend, aud_req, acr_pend};
    assign pending  = |req;
    assign more_ok  = (npk < 5'(MAX_PKTS));
    assign room_ok  = (hcnt <= 11'(ROOM_MAX));
    assign next_act = (vcnt < 10'(V_ACTIVE - 1))
                   || (vcnt == 10'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            npk   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            npk   <= npk_nx;
        end
    end

    // cur_* describes the pixel at hcnt now, including a window start.
    always_comb begin
        cur_state = state;
        cur_cnt   = cnt;
        if (state == S_IDLE && hcnt == 11'(ISL_START) && pending) begin
            cur_state = S_PRE;
            cur_cnt   = '0;
        end
        state_nx = cur_state;
        cnt_nx   = cur_cnt + 5'd1;
        npk_nx   = npk;
        win      = '0;
        unique case (cur_state)
            S_IDLE: cnt_nx = '0;
            S_PRE: begin
                npk_nx = '0;
                if (cur_cnt == 5'(PREAMBLE_LEN - 1)) begin
                    state_nx = S_LGUARD;
                    cnt_nx   = '0;
                end
            end
            S_LGUARD: begin
                if (cur_cnt == 5'(GUARD_LEN - 1)) begin
                    state_nx = S_PKT;
                    cnt_nx   = '0;
                end
            end
            S_PKT: begin
                if (cur_cnt == '0) begin
                    win    = pick(req);
                    npk_nx = npk + 5'd1;
                end
                if (cur_cnt == 5'(PACKET_LEN - 1)) begin
                    cnt_nx = '0;
                    if (!(pending && more_ok && room_ok))
                        state_nx = S_TGUARD;
                end
            end
            S_TGUARD: begin
                if (cur_cnt == 5'(GUARD_LEN - 1)) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        period_d = CTRL;
        src_d    = pkt_src;
        word_d   = '0;
        first_d  = 1'b0;
        unique case (1'b1)
            win[ACR]: src_d = ACR;
            win[AUD]: src_d = AUD;
            win[AVI]: src_d = AVI;
            win[AIF]: src_d = AIF;
            default:  src_d = pkt_src;
        endcase
        unique case (cur_state)
            S_PRE:    period_d = ISL_PRE;
            S_LGUARD: begin
                period_d = ISL_GUARD;
                first_d  = 1'b1;
            end
            S_PKT: begin
                period_d = ISL_PKT;
                word_d   = cur_cnt;
            end
            S_TGUARD: period_d = ISL_GUARD;
            default: begin
                unique case (1'b1)
                    hcnt < 11'(H_ACTIVE) && vcnt < 10'(V_ACTIVE):
                        period_d = VIDEO;
                    next_act && hcnt >= 11'(H_TOTAL - 10)
                             && hcnt <= 11'(H_TOTAL - 3):
                        period_d = VID_PRE;
                    next_act && hcnt >= 11'(H_TOTAL - 2):
                        period_d = VID_GUARD;
                    default:
                        period_d = CTRL;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period    <= CTRL;
            pkt_src   <= ACR;
            pkt_word  <= '0;
            grant     <= '0;
            isl_first <= 1'b0;
        end else begin
            period    <= period_d;
            pkt_src   <= src_d;
            pkt_word  <= word_d;
            grant     <= win;
            isl_first <= first_d;
        end
    end

`ifdef ISLAND_STATS_EN
    logic [15:0] miss_q;
    logic        isl_line;
    logic        miss_ev;

    assign miss_ev = aud_req && (
        (cur_state == S_TGUARD && cur_cnt == 5'(GUARD_LEN - 1)) ||
        (cur_state == S_IDLE && !isl_line && hcnt == 11'(ISL_LIMIT)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q   <= '0;
            isl_line <= 1'b0;
        end else begin
            if (hcnt == 11'd0)
                isl_line <= 1'b0;
            else if (cur_state == S_PRE)
                isl_line <= 1'b1;
            if (miss_ev && miss_q != 16'hFFFF)
                miss_q <= miss_q + 16'd1;
        end
    end

    assign aud_miss = miss_q;
`endif

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Scoreboard bench: a line-offset reference model predicts every pixel,
// a monitor compares DUT outputs one cycle later.
module tb_hdmi_island_scheduler;
    import hdmi_island_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcnt = '0;
    logic [9:0]  vcnt = 10'd720;
    logic        aud_req = 1'b0;
    period_t     period;
    pkt_src_t    pkt_src;
    logic [4:0]  pkt_word;
    logic [3:0]  grant;
    logic        isl_first;

    hdmi_island_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hcnt     (hcnt),
        .vcnt     (vcnt),
        .aud_req  (aud_req),
        .period   (period),
        .pkt_src  (pkt_src),
        .pkt_word (pkt_word),
        .grant    (grant),
        .isl_first(isl_first)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] p;
        logic [1:0] s;
        logic [4:0] w;
        logic [3:0] g;
        logic       f;
        int         line;
        int         h;
    } exp_t;

    typedef struct {
        int         line;
        int         h;
        logic [2:0] p;
        logic [3:0] g;
        logic       f;
    } dir_t;

    exp_t expq[$];
    dir_t dirs[$];
    exp_t me;
    int   total = 0;
    int   bad = 0;
    int   line_no = 0;
    int   aud_cnt = 0;

    // Reference model: island position counted in pixels from window start.
    bit         m_acr, m_avi, m_aif;
    int         m_line, pos, tg, npk;
    logic [1:0] last_src;

    task automatic model_reset();
        m_acr = 0; m_avi = 1; m_aif = 1;
        m_line = 0; pos = -1; tg = -1; npk = 0;
        last_src = 2'd0;
    endtask

    task automatic model_step(input int h, input int v, input bit aud,
                              output exp_t e);
        bit any, nxt, acr_set, info_set;
        int k, win;
        any = m_acr || aud || m_avi || m_aif;
        nxt = (v < 719) || (v == 835);
        e.p = CTRL; e.s = last_src; e.w = '0; e.g = '0; e.f = 0;
        e.line = 0; e.h = h;
        win = -1;
        if (pos < 0 && h == 1296 && any) begin
            pos = 0; tg = -1; npk = 0;
        end
        if (pos >= 0) begin
            if (tg >= 0 && pos >= tg) e.p = ISL_GUARD;
            else if (pos < 8) e.p = ISL_PRE;
            else if (pos < 10) begin
                e.p = ISL_GUARD; e.f = 1;
            end else begin
                k = pos - 10;
                e.p = ISL_PKT;
                e.w = 5'(k % 32);
                if (k % 32 == 0) begin
                    if (m_acr) win = 0;
                    else if (aud) win = 1;
                    else if (m_avi) win = 2;
                    else if (m_aif) win = 3;
                    if (win >= 0) begin
                        e.g = 4'(1 << win);
                        last_src = 2'(win);
                        e.s = last_src;
                    end
                    npk++;
                end
                if (k % 32 == 31 && !(any && npk < 18 && h + 35 <= 1488))
                    tg = pos + 1;
            end
            pos++;
            if (tg >= 0 && pos >= tg + 2) pos = -1;
        end else if (h < 1280 && v < 720) e.p = VIDEO;
        else if (nxt && h >= 1502 && h <= 1509) e.p = VID_PRE;
        else if (nxt && h >= 1510) e.p = VID_GUARD;
        acr_set = 0;
        if (h == 0) begin
            acr_set = (m_line == 0);
            m_line = (m_line + 1) % 4;
        end
        info_set = (h == 0 && v == 720);
        m_acr = acr_set || (m_acr && win != 0);
        m_avi = info_set || (m_avi && win != 2);
        m_aif = info_set || (m_aif && win != 3);
    endtask

    task automatic drive(input int h, input int v);
        exp_t e;
        hcnt = 11'(h);
        vcnt = 10'(v);
        aud_req = (aud_cnt > 0);
        model_step(h, v, aud_req, e);
        e.line = line_no;
        expq.push_back(e);
        @(posedge clk);
        #2;
        if (e.g[1] && aud_cnt > 0) aud_cnt--;
    endtask

    task automatic do_line(input int v, input int aud);
        aud_cnt = aud;
        for (int h = 0; h < 1512; h++) drive(h, v);
        line_no++;
    endtask

    task automatic add_dir(input int l, input int h, input logic [2:0] p,
                           input logic [3:0] g, input logic f);
        dir_t d;
        d.line = l; d.h = h; d.p = p; d.g = g; d.f = f;
        dirs.push_back(d);
    endtask

    task automatic chk_rst(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Monitor: one expected entry per driven pixel, compared a cycle later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                me = expq.pop_front();
                total++;
                if (period !== me.p || pkt_src !== me.s || pkt_word !== me.w
                    || grant !== me.g || isl_first !== me.f) begin
                    bad++;
                    if (bad <= 25)
                        $display("FAIL sb line=%0d h=%0d got p=%0d s=%0d w=%0d g=%b f=%b want p=%0d s=%0d w=%0d g=%b f=%b",
                                 me.line, me.h, period, pkt_src, pkt_word,
                                 grant, isl_first, me.p, me.s, me.w, me.g,
                                 me.f);
                end
                foreach (dirs[i]) begin
                    if (dirs[i].line == me.line && dirs[i].h == me.h) begin
                        total++;
                        if (period !== dirs[i].p || grant !== dirs[i].g
                            || isl_first !== dirs[i].f) begin
                            bad++;
                            $display("FAIL dir line=%0d h=%0d got p=%0d g=%b f=%b want p=%0d g=%b f=%b",
                                     me.line, me.h, period, grant, isl_first,
                                     dirs[i].p, dirs[i].g, dirs[i].f);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int r, v, a;
        add_dir(0, 1295, CTRL, 4'b0000, 0);
        add_dir(0, 1296, ISL_PRE, 4'b0000, 0);
        add_dir(0, 1303, ISL_PRE, 4'b0000, 0);
        add_dir(0, 1304, ISL_GUARD, 4'b0000, 1);
        add_dir(0, 1305, ISL_GUARD, 4'b0000, 1);
        add_dir(0, 1306, ISL_PKT, 4'b0001, 0);
        add_dir(0, 1338, ISL_PKT, 4'b0100, 0);
        add_dir(0, 1370, ISL_PKT, 4'b1000, 0);
        add_dir(0, 1402, ISL_GUARD, 4'b0000, 0);
        add_dir(0, 1403, ISL_GUARD, 4'b0000, 0);
        add_dir(0, 1404, CTRL, 4'b0000, 0);
        add_dir(1, 0, VIDEO, 4'b0000, 0);
        add_dir(1, 1296, CTRL, 4'b0000, 0);
        add_dir(1, 1501, CTRL, 4'b0000, 0);
        add_dir(1, 1502, VID_PRE, 4'b0000, 0);
        add_dir(1, 1509, VID_PRE, 4'b0000, 0);
        add_dir(1, 1510, VID_GUARD, 4'b0000, 0);
        add_dir(1, 1511, VID_GUARD, 4'b0000, 0);
        add_dir(2, 1502, CTRL, 4'b0000, 0);
        add_dir(2, 1511, CTRL, 4'b0000, 0);
        add_dir(3, 1502, VID_PRE, 4'b0000, 0);
        add_dir(3, 1510, VID_GUARD, 4'b0000, 0);
        add_dir(4, 1306, ISL_PKT, 4'b0001, 0);
        add_dir(4, 1338, ISL_PKT, 4'b0010, 0);
        add_dir(4, 1434, ISL_PKT, 4'b0010, 0);
        add_dir(4, 1465, ISL_PKT, 4'b0000, 0);
        add_dir(4, 1466, ISL_GUARD, 4'b0000, 0);
        add_dir(4, 1467, ISL_GUARD, 4'b0000, 0);
        add_dir(4, 1468, CTRL, 4'b0000, 0);
        add_dir(6, 1400, CTRL, 4'b0000, 0);
        add_dir(7, 1295, CTRL, 4'b0000, 0);
        add_dir(7, 1296, ISL_PRE, 4'b0000, 0);

        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        do_line(720, 0);
        do_line(100, 0);
        do_line(719, 0);
        do_line(835, 0);
        do_line(10, 12);

        // AVI word 0 lands on hcnt==0 of line 720: set and grant coincide.
        aud_cnt = 0;
        for (int h = 0; h < 1306; h++) drive(h, 720);
        for (int h = 0; h < 1512; h++) drive(h, 720);
        line_no++;

        // Reset asserted while pkt_word shows 10, released at hcnt 1400.
        aud_cnt = 0;
        for (int h = 0; h < 1317; h++) drive(h, 720);
        rst_n = 1'b0;
        #1;
        chk_rst("rst_period", int'(period), int'(CTRL));
        chk_rst("rst_src", int'(pkt_src), int'(ACR));
        chk_rst("rst_word", int'(pkt_word), 0);
        chk_rst("rst_grant", int'(grant), 0);
        chk_rst("rst_first", int'(isl_first), 0);
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int h = 1400; h < 1512; h++) drive(h, 720);
        line_no++;
        do_line(721, 0);

        for (int i = 0; i < 22; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) v = 720;
            else if (r < 3) v = 719;
            else if (r < 4) v = 835;
            else v = $urandom_range(0, 835);
            a = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 7);
            do_line(v, a);
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdmi_island_scheduler.md
Name: hdmi_island_scheduler

Overview:
- Per-line sequencer for the HDMI link period structure at the pixel clock: video, control, preamble, guard band and data-island packet slots.
- Shares the horizontal-blanking island window between four packet sources: ACR, audio sample, AVI InfoFrame and audio InfoFrame.
- Sits between the video timing counters and the TMDS encoder/packet assembler.
- Drives the encoder's period select and the assembler's packet source and word index.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_TOTAL, 1512, total pixels per line (equals widthMax)
- V_ACTIVE, 720, active lines
- V_TOTAL, 836, total lines (equals heightMax)
- ISL_GAP, 16, control pixels between end of active video and island preamble start
- ISL_LIMIT, 1488, last hcnt+1 an island (incl. trailing guard) may occupy
- MAX_PKTS, 18, packet cap per island
- ACR_LINES, 4, lines between ACR requests

Ports:
- clk, in, 1, pixel clock
- rst_n, in, 1, asynchronous active-low reset
- hcnt, in, 11, pixel counter 0..H_TOTAL-1, from timing generator
- vcnt, in, 10, line counter 0..V_TOTAL-1
- aud_req, in, 1, level: ≥1 audio sample packet ready
- period, out, 3, period_t: CTRL, VID_PRE, VID_GUARD, VIDEO, ISL_PRE, ISL_GUARD, ISL_PKT
- pkt_src, out, 2, pkt_src_t: ACR, AUD, AVI, AIF; valid in ISL_PKT
- pkt_word, out, 5, word index 0..31 within the packet
- grant, out, 4, one-hot, one-cycle pulse at pkt_word==0 of each packet
- isl_first, out, 1, high during the leading guard; the trailing guard is marked by period==ISL_GUARD && !isl_first

Behaviour:
- Reset values: period=CTRL, pkt_src=ACR, pkt_word=0, grant=0, isl_first=0.
- Reset state: AVI and AIF pending latches set to 1, ACR line counter 0.
- All outputs are registered. Outputs in cycle t+1 describe the pixel at hcnt(t).
- VIDEO: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
- VID_PRE / VID_GUARD apply only when the next line is active (vcnt<V_ACTIVE-1 or vcnt==V_TOTAL-1):
  - VID_PRE at hcnt H_TOTAL-10..H_TOTAL-3
  - VID_GUARD at hcnt H_TOTAL-2..H_TOTAL-1
- Island FSM states: IDLE, PRE(8), LGUARD(2), PKT(32), TGUARD(2).
  - IDLE→PRE at hcnt==H_ACTIVE+ISL_GAP, only if any request is pending; otherwise no island this line.
  - PRE→LGUARD→PKT.
  - At PKT word 31 → PKT again only if all hold:
    - a request is pending
    - packets sent < MAX_PKTS
    - hcnt+1+32+2 ≤ ISL_LIMIT
  - Otherwise PKT word 31 → TGUARD → IDLE.
  - Islands run on every line, active or vblank.
- Arbitration at each packet start, fixed priority ACR > AUD > AVI > AIF. The winner's grant pulses and pkt_src is held for 32 cycles.
- Requests:
  - ACR: internal latch, set when hcnt==0 and the line counter wraps at ACR_LINES; cleared on grant.
  - AVI/AIF: latches set at hcnt==0, vcnt==V_ACTIVE; cleared on grant.
  - AUD: external level. The source deasserts within 1 cycle of grant if empty, so the next arbitration sees the updated level.
- Simultaneous set and grant on a latch: set wins (stays pending).
- Async reset mid-island drops the island immediately. After release the FSM waits for the next window start; no partial island.

Optional Feature:
- Macro ISLAND_STATS_EN.
- When defined, adds output aud_miss[15:0], a saturating count of lines where aud_req is still high when TGUARD ends or the window passes with no island. The count resets to 0.
- When undefined, the port and logic are absent.

Decomposition:
- Shared package holds:
  - period_t and pkt_src_t enums
  - PREAMBLE_LEN=8, GUARD_LEN=2, PACKET_LEN=32
- One sub-module, hdmi_req_tracker: the ACR line counter plus the AVI/AIF/ACR pending latches, with clear-on-grant.

Test Plan:
- Reset release at hcnt=0, vcnt=720:
  - line 720 island: PRE at 1296..1303, LGUARD 1304..1305
  - grants ACR@1306, AVI@1338, AIF@1370; TGUARD 1402..1403
- aud_req held high on an active line with ACR pending → 5 packets (ACR then 4 AUD), TGUARD at 1466..1467, never past ISL_LIMIT.
- No requests pending (aud_req=0, all latches clear) → period stays CTRL through hblank except VID_PRE 1502..1509, VID_GUARD 1510..1511.
- vcnt=719 → no VID_PRE/VID_GUARD at line end.
- vcnt=835 → VID_PRE/VID_GUARD present at line end.
- AVI set-event coincides with an AVI grant cycle → AVI latch remains pending; AVI is granted again in the next island.
- rst_n low at pkt_word=10 → outputs return to reset values asynchronously. After release at hcnt=1400, no island until the next line's hcnt=1296.
